pipe_hazard_sequencer: RTL and testbench
========================================

Name: pipe_hazard_sequencer

Overview:
- Central hazard controller for the 4-stage in-order teaching pipeline (IF, ID, EX, MEM/WB).
- Tracks destination registers in flight in EX and MEM.
- Decides forwarding selects, load-use stalls, single-branch-in-flight stalls and mispredict flush sequencing.
- Drives pipeline-register enables/bubbles, and keeps saturating stall/flush event counters for debug readout.

Parameters:
REG_W, 5, register-index width (rs1/rs2/rd)
FLUSH_CYC, 2, cycles of flush asserted after a mispredict (1..7)
CNT_W, 8, width of each saturating performance counter

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
id_valid  in  1  valid instruction in ID
id_rs1  in  REG_W  source reg A
id_rs2  in  REG_W  source reg B
id_rd  in  REG_W  destination reg
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_is_branch  in  1  instruction is a conditional branch
br_resolve  in  1  branch in EX resolves this cycle
br_mispredict  in  1  qualifies br_resolve; prediction wrong
pc_en  out  1  advance PC / IF
ifid_en  out  1  load IF/ID register
idex_bubble  out  1  insert NOP into ID/EX instead of ID instruction
flush  out  1  kill IF/ID and ID/EX contents
fwd_a  out  2  00 regfile, 01 from EX, 10 from MEM
fwd_b  out  2  same encoding for rs2
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of mispredict events

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: RUN, scoreboard empty, branch-outstanding flag 0, both counters 0.
- Outputs after reset: pc_en=1, ifid_en=1, idex_bubble=0, flush=0, fwd_a=fwd_b=00.
- Reset mid-operation clears everything within the same cycle (async).
- Scoreboard: two registered entries, EX and MEM, each holding {v, we, ld, rd}.
  - Every cycle, MEM <= EX.
  - EX <= the ID instruction if it is accepted; otherwise a bubble (v=0).
  - Accepted = id_valid & ~idex_bubble & ~flush.
- Match rule: entry v & we & (rd == rs) & (rd != 0).
- Forwarding is combinational:
  - fwd_x = 01 if EX matches and EX.ld=0.
  - Else fwd_x = 10 if MEM matches (loads allowed).
  - Else fwd_x = 00.
  - EX has priority over MEM.
- Load-use hazard: id_valid and EX matches rs1 or rs2 with EX.ld=1 gives a 1-cycle stall.
- Branch hold:
  - The outstanding flag sets when a branch is accepted and clears on br_resolve.
  - id_is_branch while the flag is set gives a stall (BRWAIT).
- Stall outputs: pc_en=0, ifid_en=0, idex_bubble=1.
- FSM states: RUN, LDSTALL, BRWAIT, FLUSH.
  - RUN -> LDSTALL on a load-use hazard.
  - RUN -> BRWAIT on a second branch.
  - LDSTALL -> RUN after 1 cycle, or -> BRWAIT if the branch condition now holds.
  - BRWAIT -> RUN when br_resolve & ~br_mispredict.
  - Any state except FLUSH -> FLUSH on br_resolve & br_mispredict. Mispredict has top priority over all stalls.
  - FLUSH is held for FLUSH_CYC cycles via a down-counter, then -> RUN.
- Stall outputs in LDSTALL/BRWAIT are driven combinationally in the cycle the hazard is detected (state register reflects it next cycle).
- Mispredict cycle and FLUSH cycles:
  - Outputs: flush=1, pc_en=1 (redirect target fetch), ifid_en=1, idex_bubble=1.
  - Scoreboard EX entry is loaded as a bubble and the branch-outstanding flag is cleared.
- br_resolve while in FLUSH is ignored (squashed path).
- stall_cnt increments on each cycle with idex_bubble=1 & ~flush. flush_cnt increments once per mispredict. Both saturate at all-ones with no wrap.
- rd==0 never creates a hazard or a forward.

Test Plan:
- Reset then idle (id_valid=0): all outputs at reset values, counters stay 0 for 10 cycles.
- ALU rd=3 accepted, next ID rs1=3: fwd_a=01. The cycle after, with a non-matching ID in between, rs2=3 gives fwd_b=10. rd=0 variant gives 00.
- Load rd=5, then ID rs2=5: exactly one cycle with pc_en=0, idex_bubble=1, then fwd_b=10 and stall_cnt=1.
- Branch accepted, second branch in ID before resolve: stall held until br_resolve=1, br_mispredict=0, then the second branch is accepted.
- br_resolve & br_mispredict during LDSTALL: flush=1 that cycle plus FLUSH_CYC cycles, EX/MEM entries become bubbles, flush_cnt=1, return to RUN.
- Force 300 stall cycles: stall_cnt saturates at 255. Assert rst_n=0 mid-FLUSH: outputs return to reset values immediately.

Source files
------------

// File: rtl/pipe_hazard_sequencer.sv
// Hazard controller for the 4-stage in-order pipeline: forwarding selects,
// load-use and branch stalls, mispredict flush sequencing, event counters.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   id_valid/rs1/rs2/rd  instruction currently in ID
//   id_we/is_load/is_branch  ID instruction attributes
//   br_resolve           branch in EX resolves this cycle
//   br_mispredict        qualifies br_resolve, prediction was wrong
//   pc_en, ifid_en       front-end advance enables
//   idex_bubble          inject NOP into ID/EX
//   flush                kill IF/ID and ID/EX
//   fwd_a, fwd_b         00 regfile, 01 EX, 10 MEM
//   stall_cnt, flush_cnt saturating debug counters
module pipe_hazard_sequencer #(
    parameter int REG_W     = 5,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             id_is_branch,
    input  logic             br_resolve,
    input  logic             br_mispredict,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        LDSTALL,
        BRWAIT,
        FLUSH
    } state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC);

    state_t           state, state_nxt;
    logic [2:0]       fcnt_q, fcnt_nxt;
    logic             br_out;

    logic             ex_v, ex_we, ex_ld;
    logic [REG_W-1:0] ex_rd;
    logic             mem_v, mem_we;
    logic [REG_W-1:0] mem_rd;

    logic ex_a, ex_b, mem_a, mem_b;
    logic mispredict, in_flush, load_use, br_hold, stall, accept;

    assign ex_a  = ex_v & ex_we & (ex_rd == id_rs1) & (ex_rd != '0);
    assign ex_b  = ex_v & ex_we & (ex_rd == id_rs2) & (ex_rd != '0);
    assign mem_a = mem_v & mem_we & (mem_rd == id_rs1) & (mem_rd != '0);
    assign mem_b = mem_v & mem_we & (mem_rd == id_rs2) & (mem_rd != '0);

    // A load in EX has no data yet, so it cannot forward; MEM can.
    assign fwd_a = (ex_a & ~ex_ld) ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
    assign fwd_b = (ex_b & ~ex_ld) ? 2'b01 : (mem_b ? 2'b10 : 2'b00);

    // Resolves arriving during FLUSH belong to the squashed path.
    assign mispredict = br_resolve & br_mispredict & (state != FLUSH);
    assign in_flush   = mispredict | (state == FLUSH);
    assign load_use   = id_valid & ex_ld & (ex_a | ex_b);
    assign br_hold    = id_valid & id_is_branch & br_out;
    assign stall      = ~in_flush & (load_use | br_hold);
    assign accept     = id_valid & ~idex_bubble & ~flush;

    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
        flush       = 1'b0;

        unique case (state)
            FLUSH: begin
                fcnt_nxt = fcnt_q - 3'd1;
                if (fcnt_q <= 3'd1) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                if (mispredict) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = FLUSH_LD;
                end else if (br_hold & ~br_resolve) begin
                    state_nxt = BRWAIT;
                end else if (load_use) begin
                    state_nxt = LDSTALL;
                end else begin
                    state_nxt = RUN;
                end
            end
        endcase

        if (in_flush) begin
            flush       = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            fcnt_q <= '0;
        end else begin
            state  <= state_nxt;
            fcnt_q <= fcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v   <= 1'b0;
            ex_we  <= 1'b0;
            ex_ld  <= 1'b0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_we <= 1'b0;
            mem_rd <= '0;
        end else begin
            mem_v  <= ex_v;
            mem_we <= ex_we;
            mem_rd <= ex_rd;
            ex_v   <= accept;
            ex_we  <= accept & id_we;
            ex_ld  <= accept & id_is_load;
            ex_rd  <= accept ? id_rd : '0;
        end
    end

    // A newly accepted branch wins over a resolve of the older one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_out <= 1'b0;
        end else if (in_flush) begin
            br_out <= 1'b0;
        end else if (accept & id_is_branch) begin
            br_out <= 1'b1;
        end else if (br_resolve) begin
            br_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (idex_bubble & ~flush & (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (mispredict & (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer: directed scenarios plus
// random traffic against a pipeline-slot reference model.
module tb_pipe_hazard_sequencer;

    localparam int REG_W     = 5;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 8;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs1 = '0;
    logic [REG_W-1:0] id_rs2 = '0;
    logic [REG_W-1:0] id_rd = '0;
    logic             id_we = 1'b0;
    logic             id_is_load = 1'b0;
    logic             id_is_branch = 1'b0;
    logic             br_resolve = 1'b0;
    logic             br_mispredict = 1'b0;
    logic             pc_en, ifid_en, idex_bubble, flush;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_sequencer #(
        .REG_W(REG_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .br_resolve(br_resolve),
        .br_mispredict(br_mispredict), .pc_en(pc_en),
        .ifid_en(ifid_en), .idex_bubble(idex_bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
    } inst_t;

    typedef struct {
        bit pc_en;
        bit ifid_en;
        bit bub;
        bit fl;
        int fa;
        int fb;
        int sc;
        int fc;
    } exp_t;

    exp_t  q[$];
    int    errors = 0;
    int    checks = 0;

    // pipe[0] = instruction now in EX, pipe[1] = now in MEM
    inst_t pipe[2];
    bit    m_br_pending;
    int    m_flush_left;
    int    m_scnt;
    int    m_fcnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input inst_t e, input int rs);
        return e.v && e.we && (e.rd == rs) && (e.rd != 0);
    endfunction

    function automatic int fwd_of(input int rs);
        if (writes(pipe[0], rs) && !pipe[0].ld) return 1;
        if (writes(pipe[1], rs)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        pipe[0] = '{0, 0, 0, 0};
        pipe[1] = '{0, 0, 0, 0};
        m_br_pending = 0;
        m_flush_left = 0;
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_en", pc_en, e.pc_en);
            chk("ifid_en", ifid_en, e.ifid_en);
            chk("idex_bubble", idex_bubble, e.bub);
            chk("flush", flush, e.fl);
            chk("fwd_a", fwd_a, e.fa);
            chk("fwd_b", fwd_b, e.fb);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
        end
    end

    // Drive one ID cycle, predict outputs, then advance the model.
    task automatic step(input bit v, input int rs1, input int rs2,
                        input int rd, input bit we, input bit ld,
                        input bit br, input bit res, input bit mis);
        exp_t  e;
        inst_t cur;
        bit    misp, infl, ld_haz, stl, acc;
        id_valid      = v;
        id_rs1        = rs1[REG_W-1:0];
        id_rs2        = rs2[REG_W-1:0];
        id_rd         = rd[REG_W-1:0];
        id_we         = we;
        id_is_load    = ld;
        id_is_branch  = br;
        br_resolve    = res;
        br_mispredict = mis;
        cur = '{v, we, ld, rd};
        misp   = res && mis && (m_flush_left == 0);
        infl   = misp || (m_flush_left > 0);
        ld_haz = pipe[0].ld && (writes(pipe[0], rs1) || writes(pipe[0], rs2));
        stl    = !infl && v && (ld_haz || (br && m_br_pending));
        e.fl      = infl;
        e.pc_en   = !stl;
        e.ifid_en = !stl;
        e.bub     = infl || stl;
        e.fa      = fwd_of(rs1);
        e.fb      = fwd_of(rs2);
        e.sc      = m_scnt;
        e.fc      = m_fcnt;
        q.push_back(e);
        @(posedge clk);
        acc = v && !infl && !stl;
        pipe[1] = pipe[0];
        pipe[0] = acc ? cur : '{0, 0, 0, 0};
        if (infl) m_br_pending = 0;
        else if (acc && br) m_br_pending = 1;
        else if (res) m_br_pending = 0;
        if (misp) m_flush_left = FLUSH_CYC;
        else if (m_flush_left > 0) m_flush_left--;
        if (stl && m_scnt < CMAX) m_scnt++;
        if (misp && m_fcnt < CMAX) m_fcnt++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit ld;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle(10);

        // EX forward, MEM forward, rd=0 never forwards
        step(1, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, 3, 0, 9, 1, 0, 0, 0, 0);
        step(1, 0, 3, 4, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 2, 1, 0, 0, 0, 0);
        idle(2);

        // load-use: one stall, then MEM forward
        step(1, 0, 0, 5, 1, 1, 0, 0, 0);
        step(1, 1, 5, 6, 1, 0, 0, 0, 0);
        step(1, 1, 5, 6, 1, 0, 0, 0, 0);
        idle(2);

        // second branch waits for correct resolve
        step(1, 1, 2, 0, 0, 0, 1, 0, 0);
        repeat (3) step(1, 3, 4, 0, 0, 0, 1, 0, 0);
        step(1, 3, 4, 0, 0, 0, 1, 1, 0);
        step(1, 3, 4, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // mispredict during load-use stall
        step(1, 0, 0, 5, 1, 1, 0, 0, 0);
        step(1, 5, 0, 7, 1, 0, 0, 1, 1);
        step(1, 5, 0, 7, 1, 0, 0, 1, 1);
        step(1, 5, 0, 7, 1, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7),
                 ld || ($urandom_range(0, 1) == 1), ld,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1);
        end

        // counter saturation through a long branch wait
        idle(4);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (300) step(1, 1, 1, 0, 0, 0, 1, 0, 0);
        chk("stall_sat", stall_cnt, CMAX);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // async reset mid-FLUSH
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_pre_rst", flush, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_flush", flush, 0);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_bubble", idex_bubble, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(5);
        step(1, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, 3, 3, 0, 0, 0, 0, 0, 0);
        idle(2);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
